muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit for the pipelined core's execute stage. It is a parametrised successor to the single-cycle ALU, generalised in XLEN and radix, and adds multi-cycle MUL/DIV modes.
- Pipeline presents an op with in_valid/in_ready and stalls fetch/decode/execute while busy.
- Result returns with a destination tag for writeback and hazard forwarding.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- BITS_PER_CYCLE, 1, bits retired per iteration (1, 2 or 4); XLEN % BITS_PER_CYCLE == 0.
- TAGW, 5, width of destination-register tag carried alongside the op.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  op presented
- in_ready  out  1  unit can accept op this cycle
- in_op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_a  in  XLEN  rs1 operand
- in_b  in  XLEN  rs2 operand
- in_tag  in  TAGW  rd of the op
- flush  in  1  kill in-flight op (branch taken in execute)
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_result  out  XLEN  result
- out_tag  out  TAGW  rd of result
- busy  out  1  op accepted and not yet consumed (for hazard stall)

Behaviour:
- Reset (reset_n low, async): state IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, out_tag=0, all datapath registers cleared.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. When in_valid and not flush, latch operands, op and tag.
  - Special case takes the fast path straight to DONE:
    - DIV/DIVU with b==0: quotient all-ones.
    - REM/REMU with b==0: remainder = a.
    - DIV with a==most-negative and b==-1: quotient = a.
    - REM with a==most-negative and b==-1: remainder = 0.
  - Otherwise go to CALC. Latch absolute values for signed operands and record the result-sign flags.
- CALC: runs N = XLEN/BITS_PER_CYCLE cycles. Counter counts N-1 down to 0; on 0 go to FIX.
  - Multiply: shift-add into a 2*XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle.
  - Divide: restoring division, BITS_PER_CYCLE quotient bits per cycle.
- FIX: one cycle.
  - Apply two's-complement sign correction.
  - Select the low half (MUL) or high half (MULH*) of the product, or quotient vs remainder.
  - Go to DONE.
- DONE: out_valid=1; out_result and out_tag stable until consumed. When out_ready, go to IDLE in the same edge. in_ready is 0 in DONE, so there is no back-to-back accept.
- Latency, accept edge to out_valid: N+2 cycles normal (34 for XLEN=32, BPC=1); 1 cycle for the fast path.
- busy = (state != IDLE).
- flush: in any state, next state is IDLE, out_valid deasserts next cycle, and no result is emitted.
  - flush has priority over in_valid in IDLE (op not accepted) and over out_ready in DONE (result discarded).
- Signedness:
  - MULHSU treats a as signed and b as unsigned.
  - MULHU, DIVU and REMU are fully unsigned.
  - Remainder sign follows the dividend; quotient is negative iff the operand signs differ and b != 0.
- Width rules: the accumulator is 2*XLEN+1 bits to hold the restoring-division trial subtract. All arithmetic is mod 2^XLEN on output.
- in_* values are sampled only on the accept edge; changes afterwards are ignored.
- Reset asserted mid-operation aborts the op immediately with no output.

Decomposition:
- Shared package: op encoding constants (MUL..REMU), FSM state encoding, helper constant MOST_NEG = 1<<(XLEN-1).
- One sub-module: muldiv_step. It is combinational: one BITS_PER_CYCLE iteration of shift-add or restoring-subtract, built from a generate loop over BITS_PER_CYCLE single-bit stages. The FSM, sign handling and handshake stay in muldiv_unit.

Test Plan:
- MUL a=7, b=-3, XLEN=32, BPC=1, out_ready=1 -> out_valid 34 cycles after accept, out_result=0xFFFFFFEB, out_tag matches in_tag; busy high throughout, in_ready low.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- Fast path:
  - DIV a=5, b=0 -> 0xFFFFFFFF, 1 cycle later.
  - REM a=5, b=0 -> 5.
  - DIV a=0x80000000, b=-1 -> 0x80000000.
  - REM a=0x80000000, b=-1 -> 0.
- Backpressure and flush:
  - out_ready=0 for 5 cycles in DONE -> result and tag held stable, in_ready=0; consumed on the out_ready pulse, in_ready=1 next cycle.
  - flush at CALC cycle 10 -> IDLE next cycle, no out_valid.
  - flush with in_valid in IDLE -> op not accepted.
- Parameter sweep: XLEN=64 with BPC=4 -> latency 18; XLEN=32 with BPC=2 -> latency 18.
  - 1000 random ops per configuration compared against a reference model.
  - reset_n pulsed mid-CALC -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op codes,
// FSM state encoding, a decoded-op payload and the most-negative constant.
package muldiv_pkg;

  localparam int unsigned MAX_XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // sel_hi: high product half for MULH*, remainder (not quotient) for REM*
  typedef struct packed {
    logic is_div;
    logic sel_hi;
    logic a_signed;
    logic b_signed;
  } op_dec_t;

  function automatic op_dec_t decode_op(input op_e op);
    op_dec_t d;
    d.is_div   = op[2];
    d.sel_hi   = op[2] ? op[1] : (op[1:0] != 2'b00);
    d.a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    d.b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    return d;
  endfunction

  // 1 << (xlen-1), returned at the widest supported width
  function automatic logic [MAX_XLEN-1:0] most_neg(input int unsigned xlen);
    return MAX_XLEN'(1) << (xlen - 1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: BITS_PER_CYCLE chained single-bit stages of
// either right-shifting shift-add multiply or left-shifting restoring divide.
// Ports: acc (2*XLEN+1 accumulator), operand (multiplicand or divisor),
// is_div (stage kind), acc_next_c (accumulator after the iteration).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [2*XLEN:0]  acc,
  input  logic [XLEN-1:0]  operand,
  input  logic             is_div,
  output logic [2*XLEN:0]  acc_next_c
);

  localparam int unsigned ACCW = 2 * XLEN + 1;

  logic [ACCW-1:0] stage [BITS_PER_CYCLE+1];

  assign stage[0] = acc;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_bit
    logic [XLEN:0]   mul_sum;
    logic [XLEN+1:0] diff;
    logic [ACCW-1:0] mul_next;
    logic [ACCW-1:0] div_next;

    // Multiply: upper half (XLEN+1 bits) absorbs the multiplicand when the
    // current multiplier LSB is set, then the whole accumulator shifts right.
    assign mul_sum  = stage[i][2*XLEN:XLEN] + (stage[i][0] ? {1'b0, operand} : '0);
    assign mul_next = {1'b0, mul_sum, stage[i][XLEN-1:1]};

    // Divide: partial remainder shifted left by one takes the next dividend
    // bit; keep the trial difference only when it did not borrow.
    assign diff     = {1'b0, stage[i][2*XLEN-1:XLEN-1]} - {2'b00, operand};
    assign div_next = diff[XLEN+1] ? {stage[i][2*XLEN-1:0], 1'b0}
                                   : {diff[XLEN:0], stage[i][XLEN-2:0], 1'b1};

    assign stage[i+1] = is_div ? div_next : mul_next;
  end

  assign acc_next_c = stage[BITS_PER_CYCLE];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Ports: clk, reset_n (async active-low); in_valid/in_ready/in_op/in_a/in_b/
// in_tag accept an op in IDLE; flush kills any in-flight op; out_valid/
// out_ready/out_result/out_tag return the result; busy flags a held op.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned TAGW           = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int unsigned N        = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNTW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ACCW     = 2 * XLEN + 1;
  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(N - 1);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [ACCW-1:0] acc_q, acc_d, acc_step;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            is_div_q, is_div_d;
  logic            sel_hi_q, sel_hi_d;
  logic            neg_q, neg_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [XLEN-1:0] res_d;
  logic [TAGW-1:0] otag_d;

  op_dec_t           dec_in;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              b_zero, div_ovf, fast;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Operand preparation on the accept cycle: magnitudes, signs, fast path
  always_comb begin
    dec_in   = decode_op(op_e'(in_op));
    a_neg    = dec_in.a_signed & in_a[XLEN-1];
    b_neg    = dec_in.b_signed & in_b[XLEN-1];
    a_abs    = a_neg ? -in_a : in_a;
    b_abs    = b_neg ? -in_b : in_b;
    b_zero   = (in_b == '0);
    // Only DIV/REM are signed on both operands among divide ops
    div_ovf  = dec_in.a_signed & dec_in.b_signed & (in_a == MOST_NEG) & (in_b == '1);
    fast     = dec_in.is_div & (b_zero | div_ovf);
    if (b_zero) fast_res = dec_in.sel_hi ? in_a : '1;
    else        fast_res = dec_in.sel_hi ? '0   : in_a;
  end

  // Sign correction and result selection used in FIX
  always_comb begin
    prod     = acc_q[2*XLEN-1:0];
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (is_div_q) fix_res = sel_hi_q ? rem_fix : quo_fix;
    else          fix_res = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  muldiv_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc        (acc_q),
    .operand    (opnd_q),
    .is_div     (is_div_q),
    .acc_next_c (acc_step)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    neg_d    = neg_q;
    tag_d    = tag_q;
    res_d    = out_result;
    otag_d   = out_tag;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            is_div_d = dec_in.is_div;
            sel_hi_d = dec_in.sel_hi;
            tag_d    = in_tag;
            if (fast) begin
              res_d   = fast_res;
              otag_d  = in_tag;
              state_d = ST_DONE;
            end else begin
              state_d = ST_CALC;
              cnt_d   = CNT_INIT;
              // Remainder sign follows the dividend only
              neg_d   = (dec_in.is_div & dec_in.sel_hi) ? a_neg : (a_neg ^ b_neg);
              if (dec_in.is_div) begin
                acc_d  = {{(XLEN+1){1'b0}}, a_abs};
                opnd_d = b_abs;
              end else begin
                acc_d  = {{(XLEN+1){1'b0}}, b_abs};
                opnd_d = a_abs;
              end
            end
          end
        end
        ST_CALC: begin
          acc_d = acc_step;
          if (cnt_q == '0) state_d = ST_FIX;
          else             cnt_d   = cnt_q - CNTW'(1);
        end
        ST_FIX: begin
          res_d   = fix_res;
          otag_d  = tag_q;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      sel_hi_q   <= 1'b0;
      neg_q      <= 1'b0;
      tag_q      <= '0;
      out_result <= '0;
      out_tag    <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      sel_hi_q   <= sel_hi_d;
      neg_q      <= neg_d;
      tag_q      <= tag_d;
      out_result <= res_d;
      out_tag    <= otag_d;
      out_valid  <= (state_d == ST_DONE);
      in_ready   <= (state_d == ST_IDLE);
      busy       <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: three configurations (32/1, 32/2, 64/4)
// share one stimulus stream; results checked against hand values and a
// native-arithmetic reference.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  in_op = 3'b000;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [4:0]  in_tag = '0;

  logic        rdy0, ov0, busy0, rdy1, ov1, busy1, rdy2, ov2, busy2;
  logic [31:0] res0, res1;
  logic [63:0] res2;
  logic [4:0]  tag0, tag1, tag2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAGW(5)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_op(in_op), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
    .flush(flush), .out_valid(ov0), .out_ready(out_ready),
    .out_result(res0), .out_tag(tag0), .busy(busy0));

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(2), .TAGW(5)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_op(in_op), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready),
    .out_result(res1), .out_tag(tag1), .busy(busy1));

  muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(4), .TAGW(5)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush), .out_valid(ov2), .out_ready(out_ready),
    .out_result(res2), .out_tag(tag2), .busy(busy2));

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // RISC-V M semantics with native arithmetic at the given width
  function automatic logic [63:0] ref_model(input int unsigned xl, input logic [2:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  mask, mn, au, bu, sa, sb, res;
    logic [127:0] x, y, p;
    logic         a_s, b_s;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn   = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    au   = a & mask;
    bu   = b & mask;
    sa   = (xl == 64) ? a : {{32{a[31]}}, a[31:0]};
    sb   = (xl == 64) ? b : {{32{b[31]}}, b[31:0]};
    a_s  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_s  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    if (!op[2]) begin
      x = a_s ? {{64{sa[63]}}, sa} : {64'h0, au};
      y = b_s ? {{64{sb[63]}}, sb} : {64'h0, bu};
      p = x * y;
      if (op == OP_MUL) res = p[63:0];
      else              res = (xl == 64) ? p[127:64] : p[95:32];
    end else if (bu == 64'h0) begin
      res = op[1] ? au : mask;
    end else if (b_s && au == mn && bu == mask) begin
      res = op[1] ? 64'h0 : au;
    end else if (b_s) begin
      res = op[1] ? 64'($signed(sa) % $signed(sb)) : 64'($signed(sa) / $signed(sb));
    end else begin
      res = op[1] ? (au % bu) : (au / bu);
    end
    return res & mask;
  endfunction

  function automatic bit is_fast(input int unsigned xl, input logic [2:0] op,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, mn;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn   = (xl == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    return op[2] && (((b & mask) == 64'h0) ||
           ((op == OP_DIV || op == OP_REM) && (a & mask) == mn && (b & mask) == mask));
  endfunction

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    // Scramble inputs after accept: only the accept edge may matter
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_tag = ~tag; in_op = ~op;
  endtask

  // Issue one op with out_ready high and check all three configurations
  task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag, input logic [31:0] exp0);
    int          lat0, lat1, lat2;
    logic [63:0] r0, r1, r2;
    logic [4:0]  t0;
    bit          hs_ok, f32, f64;
    f32 = is_fast(32, op, a, b);
    f64 = is_fast(64, op, a, b);
    lat0 = 0; lat1 = 0; lat2 = 0; hs_ok = 1'b1;
    r0 = 'x; r1 = 'x; r2 = 'x; t0 = 'x;
    issue(op, a, b, tag);
    for (int c = 1; c <= 200; c++) begin
      if (lat0 == 0 && ov0) begin lat0 = c; r0 = 64'(res0); t0 = tag0; end
      else if (lat0 == 0 && !(busy0 && !rdy0)) hs_ok = 1'b0;
      if (lat1 == 0 && ov1) begin lat1 = c; r1 = 64'(res1); end
      if (lat2 == 0 && ov2) begin lat2 = c; r2 = res2; end
      if (lat0 != 0 && lat1 != 0 && lat2 != 0) break;
      @(posedge clk); #1;
    end
    check({name, "/lat32x1"}, 64'(lat0), f32 ? 64'd1 : 64'd34);
    check({name, "/res32x1"}, r0, 64'(exp0));
    check({name, "/tag32x1"}, 64'(t0), 64'(tag));
    if (!f32) check({name, "/busy_noready"}, 64'(hs_ok), 64'd1);
    check({name, "/lat32x2"}, 64'(lat1), f32 ? 64'd1 : 64'd18);
    check({name, "/res32x2"}, r1, ref_model(32, op, a, b));
    check({name, "/lat64x4"}, 64'(lat2), f64 ? 64'd1 : 64'd18);
    check({name, "/res64x4"}, r2, ref_model(64, op, a, b));
    @(posedge clk); #1;
    check({name, "/ready_after"}, {61'h0, rdy0, rdy1, rdy2}, 64'h7);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit          seen;
    logic [2:0]  rop;
    logic [63:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    check("reset/hs", {61'h0, ov0, rdy0, busy0}, 64'h2);
    check("reset/result", 64'(res0), 64'h0);
    check("reset/tag", 64'(tag0), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors; expected values for the 32-bit view by hand
    run_op("mul_7_m3",     OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
    run_op("mulhu_ff",     OP_MULHU,  64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 5'd4, 32'hFFFF_FFFE);
    run_op("mulh_ff",      OP_MULH,   64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 5'd5, 32'h0000_0000);
    run_op("mulhsu_m1",    OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
    run_op("mulhu_2",      OP_MULHU,  64'h0000_0000_8000_0000, 64'd4, 5'd7, 32'h0000_0002);
    run_op("div_m7_2",     OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 32'hFFFF_FFFD);
    run_op("rem_m7_2",     OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 32'hFFFF_FFFF);
    run_op("div_7_m3",     OP_DIV,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd10, 32'hFFFF_FFFE);
    run_op("rem_7_m3",     OP_REM,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd11, 32'h0000_0001);
    run_op("divu_100_7",   OP_DIVU,   64'd100, 64'd7, 5'd12, 32'd14);
    run_op("remu_100_7",   OP_REMU,   64'd100, 64'd7, 5'd13, 32'd2);
    run_op("div_by0",      OP_DIV,    64'd5, 64'd0, 5'd14, 32'hFFFF_FFFF);
    run_op("rem_by0",      OP_REM,    64'd5, 64'd0, 5'd15, 32'd5);
    run_op("divu_by0",     OP_DIVU,   64'd9, 64'd0, 5'd16, 32'hFFFF_FFFF);
    run_op("div_ovf",      OP_DIV,    64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 32'h8000_0000);
    run_op("rem_ovf",      OP_REM,    64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd18, 32'h0000_0000);

    // Backpressure: result and tag held while out_ready is low
    out_ready = 1'b0;
    issue(OP_DIVU, 64'd100, 64'd7, 5'd9);
    for (int c = 0; c < 100 && !ov0; c++) begin @(posedge clk); #1; end
    check("bp/valid", 64'(ov0), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp/result_held", 64'(res0), 64'd14);
      check("bp/tag_held", 64'(tag0), 64'd9);
      check("bp/hs_held", {61'h0, ov0, rdy0, busy0}, 64'h5);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp/consumed", {61'h0, ov0, rdy0, busy0}, 64'h2);

    // Flush in DONE discards the pending result
    out_ready = 1'b0;
    issue(OP_MUL, 64'd6, 64'd7, 5'd4);
    for (int c = 0; c < 100 && !ov0; c++) begin @(posedge clk); #1; end
    check("flush_done/valid", 64'(res0), 64'd42);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_done/hs", {61'h0, ov0, rdy0, busy0}, 64'h2);
    check("flush_done/others", {62'h0, ov1, ov2}, 64'h0);
    out_ready = 1'b1;

    // Flush on the tenth CALC edge
    issue(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd21);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_calc/hs", {61'h0, ov0, rdy0, busy0}, 64'h2);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= ov0 | ov1 | ov2; end
    check("flush_calc/no_output", 64'(seen), 64'd0);

    // Flush beats in_valid in IDLE
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_op = OP_DIVU; in_a = 64'd50; in_b = 64'd5; in_tag = 5'd22;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle/hs", {61'h0, ov0, rdy0, busy0}, 64'h2);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= ov0 | ov1 | ov2 | busy0 | busy1 | busy2; end
    check("flush_idle/no_accept", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of CALC
    issue(OP_DIVU, 64'd1000, 64'd3, 5'd23);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mid/hs", {61'h0, ov0, rdy0, busy0}, 64'h2);
    check("rst_mid/result", 64'(res0), 64'h0);
    check("rst_mid/tag", 64'(tag0), 64'h0);
    check("rst_mid/busy64", 64'(busy2), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    run_op("after_reset", OP_DIVU, 64'd1000, 64'd3, 5'd24, 32'd333);

    // Random ops across all three configurations against the reference
    for (int i = 0; i < 1000; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = 64'h0;
        1: begin ra = 64'h8000_0000_0000_0000; rb = '1; end
        2: begin ra = 64'hFFFF_FFFF_8000_0000; rb = '1; end
        3: rb = rb >> 48;
        4: rb = 64'(signed'(rb[15:0]));
        default: ;
      endcase
      run_op("rand", rop, ra, rb, 5'($urandom), 32'(ref_model(32, rop, ra, rb)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
